multi_phase_pwm: RTL and testbench
==================================

# multi_phase_pwm

Parametrised N-channel PWM generator with edge-aligned and valley-centred modes, period-boundary shadow loading and complementary high/low outputs with dead-time insertion. It drives the gate-driver pins of multi-leg inverter stages. It also exports the carrier count, direction and a period-start strobe so ADC-trigger and control-loop logic can synchronise to it.

## Interface
- CHANNELS, 3, number of PWM legs (1..8)
- WIDTH, 16, counter/period/duty width in bits
- DT_WIDTH, 8, dead-time width in bits
- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Period  in  WIDTH  carrier top value P
- Duty  in  CHANNELS*WIDTH  channel i duty at [i*WIDTH +: WIDTH]
- DeadTime  in  DT_WIDTH  dead-time cycles DT
- Mode  in  1  0 = edge-aligned, 1 = valley-centred up/down
- Enable  in  1  output enable (not shadowed)
- PwmHigh  out  CHANNELS  high-side gate per channel
- PwmLow  out  CHANNELS  low-side gate per channel
- Count  out  WIDTH  current carrier count
- Dir  out  1  1 = counting up, 0 = down
- PeriodStart  out  1  one-cycle strobe after each boundary

## Operation
- Shadow registers P_s, D_s[i], DT_s, M_s load from the inputs only in a boundary cycle. D_s[i] = min(Duty[i], Period + 1), computed at WIDTH+1 bits.
- Boundary: edge mode when Count >= P_s; centre mode when Count == 0 and Dir == 0.
- Every boundary sets Count <= 0 and Dir <= 1, loads the shadows, and sets PeriodStart <= 1 for the next cycle.
- Edge mode: Count runs 0..P then wraps. Period is P+1 cycles. Dir is held 1.
- Centre mode: up from 0 to P, then Dir <= 0 and Count <= P-1 next cycle, down to 0. Period is 2P+1 cycles, 0 occurring twice (up and down).
- P_s = 0: boundary every cycle; Count stays 0.
- Raw[i] is a register: raw compare (Count < D_s[i]) AND Enable.
- Resulting high time: edge D_s cycles; centre 2*D_s cycles, centred on the valley, capped at 2P+1.
- Dead-time unit, per channel, with counter dt[i]:
  - Raw rise: PwmLow <= 0 next cycle. PwmHigh asserts after DT_s further cycles with both outputs low.
  - Raw fall: symmetric, swapping PwmHigh and PwmLow.
  - Raw toggles while dt[i] is running: dt restarts for the new level and both outputs stay low, so pulses shorter than DT_s are swallowed.
  - DT_s = 0: PwmHigh = Raw, PwmLow = ~Raw.
- Enable low: PwmHigh and PwmLow are 0 the cycle after Enable is sampled low, and dt[i] is cleared.
- Enable rising: both outputs start low. The side matching Raw asserts after DT_s cycles.
- PwmHigh and PwmLow are never both 1, in any mode and on any cycle.

## Timing
- Reset values: Count 0, Dir 0, PwmHigh 0, PwmLow 0, PeriodStart 0, all shadows 0, M_s = edge.
- First cycle after Reset deasserts is a boundary (P_s = 0), so inputs are loaded immediately. PeriodStart is high on the following cycle.
- Latency with DT_s = 0: a Count value at cycle t determines PwmHigh/PwmLow at t+2.
- Input changes (Period, Duty, DeadTime, Mode) take effect only from the cycle after the next boundary. There are no mid-period glitches.
- A Mode change lands at a boundary; the new mode's period starts at Count 0, Dir 1.
- Reset asserted mid-period: all registers return to reset values on the next edge. Outputs are low one cycle after Reset is sampled.
- Unsigned arithmetic throughout. The duty clamp uses a WIDTH+1-bit compare, so Period = 2^WIDTH−1 is legal.

## Configuration
- PWM_DEADTIME_EN defined: dead-time unit and dt counters are instantiated as in Operation.
- PWM_DEADTIME_EN undefined: DeadTime is ignored and DT_s is not built.
  - PwmHigh = Raw and PwmLow = ~Raw while Enable is high; both outputs are 0 while it is low.
  - The same output register stage is kept, so latency is unchanged (t+2).

## Test plan
- Edge mode, P=9, Duty = {10,5,3}, DT=0 -> 10-cycle period. High times 3, 5, 10 (ch2 at 100%, PwmLow2 constant 0). PeriodStart every 10 cycles.
- Centre mode, P=4, D0=2, DT=0 -> 9-cycle period. PwmHigh0 high 4 consecutive cycles centred on the valley. Dir low for 4 cycles per period.
- Edge mode, P=9, D=5, DT=2 -> PwmHigh 3 cycles, PwmLow 3 cycles, 2 both-low cycles at each transition. Never both high.
- Edge mode, P=9, D=1, DT=2 -> PwmHigh never asserts. PwmLow drops for 3 cycles per period.
- Change Duty 3->7 and Period 9->19 mid-period -> old waveform until the boundary. New waveform starts the cycle after PeriodStart.
- Enable dropped while PwmHigh is high -> both outputs 0 the next cycle. Reset pulsed mid-period -> all outputs 0, Count 0, first boundary one cycle after release.

Source files
------------

// File: rtl/multi_phase_pwm.sv
// N-channel PWM carrier (edge-aligned or valley-centred) with shadowed settings and
// complementary gate outputs. Define PWM_DEADTIME_EN to build the per-channel dead-time unit.
module multi_phase_pwm #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [WIDTH-1:0]          Period,
    input  logic [CHANNELS*WIDTH-1:0] Duty,
    input  logic [DT_WIDTH-1:0]       DeadTime,
    input  logic                      Mode,
    input  logic                      Enable,
    output logic [CHANNELS-1:0]       PwmHigh,
    output logic [CHANNELS-1:0]       PwmLow,
    output logic [WIDTH-1:0]          Count,
    output logic                      Dir,
    output logic                      PeriodStart
);

    typedef enum logic {
        ModeEdge   = 1'b0,
        ModeCentre = 1'b1
    } mode_e;

    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    logic [WIDTH-1:0] period_s;
    mode_e            mode_s;
    logic             boundary;
    logic [WIDTH:0]   period_ext;

    // Period + 1 at WIDTH+1 bits so a full-scale Period still clamps correctly.
    assign period_ext = {1'b0, Period} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        boundary = 1'b0;
        if (period_s == '0) begin
            boundary = 1'b1;
        end else if (mode_s == ModeCentre) begin
            boundary = (Count == '0) && !Dir;
        end else begin
            boundary = (Count >= period_s);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Count       <= '0;
            Dir         <= 1'b0;
            PeriodStart <= 1'b0;
            period_s    <= '0;
            mode_s      <= ModeEdge;
        end else begin
            PeriodStart <= boundary;
            if (boundary) begin
                Count    <= '0;
                Dir      <= 1'b1;
                period_s <= Period;
                mode_s   <= mode_e'(Mode);
            end else if (mode_s == ModeEdge) begin
                Count <= Count + CntOne;
                Dir   <= 1'b1;
            end else if (Dir) begin
                if (Count >= period_s) begin
                    Dir   <= 1'b0;
                    Count <= period_s - CntOne;
                end else begin
                    Count <= Count + CntOne;
                end
            end else begin
                Count <= Count - CntOne;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DT_WIDTH-1:0] dt_s;
    logic                en_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dt_s <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= Enable;
            if (boundary) begin
                dt_s <= DeadTime;
            end
        end
    end
`else
    logic unused_dead_time;
    assign unused_dead_time = ^DeadTime;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH:0] duty_in;
        logic [WIDTH:0] duty_clamped;
        logic [WIDTH:0] duty_s;
        logic           raw;
        logic           high_q;
        logic           low_q;

        assign duty_in      = {1'b0, Duty[i*WIDTH +: WIDTH]};
        assign duty_clamped = (duty_in < period_ext) ? duty_in : period_ext;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                duty_s <= '0;
                raw    <= 1'b0;
            end else begin
                if (boundary) begin
                    duty_s <= duty_clamped;
                end
                raw <= Enable && ({1'b0, Count} < duty_s);
            end
        end

`ifdef PWM_DEADTIME_EN
        logic [DT_WIDTH-1:0] dt_cnt;
        logic                raw_q;

        // Any raw edge (or enable rising) forces both gates low and restarts the dead time.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                high_q <= 1'b0;
                low_q  <= 1'b0;
                dt_cnt <= '0;
                raw_q  <= 1'b0;
            end else begin
                raw_q <= raw;
                if (!Enable) begin
                    high_q <= 1'b0;
                    low_q  <= 1'b0;
                    dt_cnt <= '0;
                end else if ((raw != raw_q) || !en_q) begin
                    if (dt_s == '0) begin
                        high_q <= raw;
                        low_q  <= !raw;
                        dt_cnt <= '0;
                    end else begin
                        high_q <= 1'b0;
                        low_q  <= 1'b0;
                        dt_cnt <= dt_s;
                    end
                end else if (dt_cnt != '0) begin
                    if (dt_cnt == DT_WIDTH'(1)) begin
                        high_q <= raw;
                        low_q  <= !raw;
                    end
                    dt_cnt <= dt_cnt - DT_WIDTH'(1);
                end
            end
        end
`else
        always_ff @(posedge Clk) begin
            if (Reset) begin
                high_q <= 1'b0;
                low_q  <= 1'b0;
            end else begin
                high_q <= Enable && raw;
                low_q  <= Enable && !raw;
            end
        end
`endif

        assign PwmHigh[i] = high_q;
        assign PwmLow[i]  = low_q;
    end

endmodule

// File: tb/tb_multi_phase_pwm.sv
// Scoreboard bench for multi_phase_pwm: a period-position reference model predicts every
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_multi_phase_pwm;
    localparam int CH  = 3;
    localparam int W   = 16;
    localparam int DTW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic [DTW-1:0]  dead_time;
    logic            mode;
    logic            enable;
    logic [CH-1:0]   pwm_high;
    logic [CH-1:0]   pwm_low;
    logic [W-1:0]    count;
    logic            dir;
    logic            period_start;

    always #5 clk = ~clk;

    multi_phase_pwm #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .DT_WIDTH(DTW)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Period     (period),
        .Duty       (duty),
        .DeadTime   (dead_time),
        .Mode       (mode),
        .Enable     (enable),
        .PwmHigh    (pwm_high),
        .PwmLow     (pwm_low),
        .Count      (count),
        .Dir        (dir),
        .PeriodStart(period_start)
    );

    typedef struct packed {
        logic [W-1:0]  cnt;
        logic          dir;
        logic          ps;
        logic [CH-1:0] hi;
        logic [CH-1:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position k inside the current carrier period plus shadow copies.
    int unsigned   m_k, m_p, m_dt;
    bit            m_mode, m_first, m_pstart, rst_prev;
    int unsigned   m_d[CH];
    bit [CH-1:0]   m_raw;
    bit            en_h[8];
    bit [CH-1:0]   raw_h[8];

    function automatic int unsigned cur_count();
        return (m_mode && m_k > m_p) ? 2 * m_p - m_k : m_k;
    endfunction

    function automatic void model_reset();
        m_k = 0; m_p = 0; m_mode = 0; m_first = 1; m_pstart = 0; m_raw = '0;
        for (int c = 0; c < CH; c++) m_d[c] = 0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit   ok_en;
        bit   stable;
        e.cnt = W'(cur_count());
        e.dir = m_first ? 1'b0 : (m_mode ? (m_k <= m_p) : 1'b1);
        e.ps  = m_pstart;
        ok_en = 1;
        for (int j = 0; j <= int'(m_dt); j++) if (!en_h[j]) ok_en = 0;
        for (int c = 0; c < CH; c++) begin
            stable = 1;
            for (int j = 1; j <= int'(m_dt); j++) if (raw_h[j][c] != raw_h[0][c]) stable = 0;
            e.hi[c] = ok_en && stable && raw_h[0][c];
            e.lo[c] = ok_en && stable && !raw_h[0][c];
        end
        return e;
    endfunction

    function automatic void advance(bit r, bit en, bit md, int unsigned per,
                                    logic [CH*W-1:0] dv);
        bit [CH-1:0] nraw;
        int unsigned cnt, len, dval;
        for (int j = 7; j > 0; j--) begin
            en_h[j]  = en_h[j-1];
            raw_h[j] = raw_h[j-1];
        end
        en_h[0]  = en && !r;
        raw_h[0] = m_raw;
        if (r) begin
            model_reset();
        end else begin
            cnt = cur_count();
            for (int c = 0; c < CH; c++) nraw[c] = en && (cnt < m_d[c]);
            len = m_mode ? 2 * m_p + 1 : m_p + 1;
            if (m_k == len - 1) begin
                m_p = per; m_mode = md; m_k = 0; m_pstart = 1;
                for (int c = 0; c < CH; c++) begin
                    dval = int'(dv[c*W +: W]);
                    m_d[c] = (dval < per + 1) ? dval : per + 1;
                end
            end else begin
                m_k++; m_pstart = 0;
            end
            m_first = 0;
            m_raw   = nraw;
        end
    endfunction

    // One clock: publish the expectation for this cycle, then apply this cycle's inputs.
    task automatic step(input bit r, input bit en, input bit md, input int unsigned per,
                        input logic [CH*W-1:0] dv, input int unsigned dt);
        bit en_eff;
        @(posedge clk);
        #1;
`ifdef PWM_DEADTIME_EN
        m_dt = dt;
`else
        m_dt = 0;
`endif
        exp_q.push_back(predict());
        // Gates stay off through the release cycle so the dead time is already loaded.
        en_eff    = en && !rst_prev;
        rst       = r;
        enable    = en_eff;
        mode      = md;
        period    = W'(per);
        duty      = dv;
        dead_time = DTW'(dt);
        advance(r, en_eff, md, per, dv);
        rst_prev = r;
    endtask

    task automatic run(input int n, input bit en, input bit md, input int unsigned per,
                       input logic [CH*W-1:0] dv, input int unsigned dt);
        for (int i = 0; i < n; i++) step(0, en, md, per, dv, dt);
    endtask

    task automatic do_reset(input int unsigned dt);
        step(1, 0, 0, 0, '0, dt);
        step(1, 0, 0, 0, '0, dt);
    endtask

    function automatic logic [CH*W-1:0] pack3(int unsigned a, int unsigned b, int unsigned c);
        return {W'(c), W'(b), W'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("count", 32'(count), 32'(e.cnt));
                chk("dir", 32'(dir), 32'(e.dir));
                chk("period_start", 32'(period_start), 32'(e.ps));
                chk("pwm_high", 32'(pwm_high), 32'(e.hi));
                chk("pwm_low", 32'(pwm_low), 32'(e.lo));
                chk("overlap", 32'(pwm_high & pwm_low), 32'd0);
            end
        end
    end

    initial begin : driver
        int unsigned per, dt;
        bit          md;
        logic [CH*W-1:0] dv;
        rst = 1; enable = 0; mode = 0; period = '0; duty = '0; dead_time = '0;
        rst_prev = 1;
        for (int j = 0; j < 8; j++) begin en_h[j] = 0; raw_h[j] = '0; end
        model_reset();
        repeat (2) @(posedge clk);

        do_reset(0); run(40, 1, 0, 9, pack3(10, 5, 3), 0);
        do_reset(0); run(40, 1, 1, 4, pack3(2, 0, 5), 0);
        do_reset(2); run(40, 1, 0, 9, pack3(5, 5, 5), 2);
        do_reset(2); run(40, 1, 0, 9, pack3(1, 1, 1), 2);
        do_reset(0); run(14, 1, 0, 9, pack3(3, 3, 3), 0); run(50, 1, 0, 19, pack3(7, 7, 7), 0);
        do_reset(1); run(13, 1, 0, 9, pack3(6, 2, 9), 1); run(1, 0, 0, 9, pack3(6, 2, 9), 1);
        run(20, 1, 0, 9, pack3(6, 2, 9), 1); step(1, 1, 0, 9, pack3(6, 2, 9), 1);
        run(25, 1, 1, 6, pack3(6, 2, 9), 1);
        do_reset(0); run(12, 1, 0, 0, pack3(0, 1, 5), 0); run(12, 1, 1, 0, pack3(0, 1, 5), 0);
        do_reset(0); run(30, 1, 0, 65535, pack3(65535, 0, 1), 0);
        do_reset(0); run(30, 1, 1, 65535, pack3(65535, 3, 70), 0);
        do_reset(0); run(30, 1, 1, 3, pack3(9, 4, 1), 0); run(30, 1, 0, 3, pack3(9, 4, 1), 0);

        for (int s = 0; s < 24; s++) begin
            dt  = $urandom_range(0, 3);
            per = $urandom_range(0, 12);
            md  = 1'($urandom_range(0, 1));
            dv  = pack3($urandom_range(0, per + 3), $urandom_range(0, per + 3),
                        $urandom_range(0, per + 3));
            do_reset(dt);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    per = $urandom_range(0, 12);
                    md  = 1'($urandom_range(0, 1));
                    dv  = pack3($urandom_range(0, per + 3), $urandom_range(0, per + 3),
                                $urandom_range(0, per + 3));
                end
                step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0, md, per, dv, dt);
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
